// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_pkg;

  // Capture FSM: idle, waiting for the first rise, then alternating high/low measurement.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_MEAS_HIGH = 2'd2,
    ST_MEAS_LOW  = 2'd3
  } pwm_cap_state_t;

  // Fewer than two synchronizer flops is never safe on an asynchronous input.
  localparam int PWM_SYNC_MIN = 2;

endpackage

// File: rtl/sync_edge.sv
// Synchronizes an asynchronous level and produces registered rise/fall pulses.
// The level output is the previous-level flop, so it lines up with rise/fall.
module sync_edge
  import pwm_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int S = (SYNC_STAGES < PWM_SYNC_MIN) ? PWM_SYNC_MIN : SYNC_STAGES;

  logic [S-1:0] sync_q, sync_d;
  logic         prev_q, prev_d;
  logic         rise_q, rise_d;
  logic         fall_q, fall_d;

  // Next-state of the synchronizer chain, previous-level flop and edge pulses.
  always_comb begin
    sync_d = {sync_q[S-2:0], din};
    prev_d = sync_q[S-1];
    rise_d = sync_q[S-1] & ~prev_q;
    fall_d = ~sync_q[S-1] & prev_q;
  end

  // All conditioning flops clear on reset, so a high input yields one rise afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = prev_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of an incoming PWM signal in clk cycles,
// flags stuck inputs with a timeout record, and hands results out through
// a single-entry valid/ready register with a sticky overrun flag.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int N           = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         pwm_in,
  output logic [N-1:0] period_count,
  output logic [N-1:0] high_count,
  output logic         timeout,
  output logic         valid,
  input  logic         ready,
  output logic         overrun
);

  localparam logic [N-1:0] MAX = {N{1'b1}};
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [N-1:0] period;
    logic [N-1:0] high;
    logic         timeout;
  } pwm_result_t;

  // Counters stop at MAX instead of wrapping.
  function automatic logic [N-1:0] sat_inc(input logic [N-1:0] v);
    return (v == MAX) ? MAX : v + ONE;
  endfunction

  logic level, rise, fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
    .clk  (clk),
    .rst  (rst),
    .din  (pwm_in),
    .level(level),
    .rise (rise),
    .fall (fall)
  );

  pwm_cap_state_t state_q, state_d;
  logic [N-1:0]   cnt_period_q, cnt_period_d;
  logic [N-1:0]   cnt_high_q, cnt_high_d;
  pwm_result_t    res_q, res_d;
  logic           valid_q, valid_d;
  logic           overrun_q, overrun_d;
  logic           emit;
  pwm_result_t    emit_res;

  // Measurement FSM: counts period/high time between rises and raises emit with a result.
  always_comb begin
    state_d      = state_q;
    cnt_period_d = cnt_period_q;
    cnt_high_d   = cnt_high_q;
    emit         = 1'b0;
    emit_res     = '0;
    if (!ena) begin
      // Any partial period is discarded.
      state_d      = ST_IDLE;
      cnt_period_d = '0;
      cnt_high_d   = '0;
    end else if (state_q == ST_IDLE) begin
      state_d      = ST_ARMED;
      cnt_period_d = '0;
      cnt_high_d   = '0;
    end else if (cnt_period_q == MAX && !rise) begin
      // Dead input: report a timeout record and wait for a fresh rise.
      emit             = 1'b1;
      emit_res.period  = MAX;
      emit_res.high    = level ? MAX : '0;
      emit_res.timeout = 1'b1;
      state_d          = ST_ARMED;
      cnt_period_d     = '0;
      cnt_high_d       = '0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (rise) begin
            cnt_period_d = ONE;
            cnt_high_d   = ONE;
            state_d      = ST_MEAS_HIGH;
          end else begin
            cnt_period_d = sat_inc(cnt_period_q);
          end
        end
        ST_MEAS_HIGH: begin
          cnt_period_d = sat_inc(cnt_period_q);
          if (fall) begin
            state_d = ST_MEAS_LOW;
          end else begin
            cnt_high_d = sat_inc(cnt_high_q);
          end
        end
        ST_MEAS_LOW: begin
          if (rise) begin
            emit             = 1'b1;
            emit_res.period  = cnt_period_q;
            emit_res.high    = cnt_high_q;
            emit_res.timeout = 1'b0;
            cnt_period_d     = ONE;
            cnt_high_d       = ONE;
            state_d          = ST_MEAS_HIGH;
          end else begin
            cnt_period_d = sat_inc(cnt_period_q);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Output register: load when empty or being drained, otherwise drop and flag overrun.
  always_comb begin
    res_d     = res_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (emit) begin
      if (!valid_q || ready) begin
        res_d   = emit_res;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // State, counters and result register; everything visible clears on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_period_q <= '0;
      cnt_high_q   <= '0;
      res_q        <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_period_q <= cnt_period_d;
      cnt_high_q   <= cnt_high_d;
      res_q        <= res_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign period_count = res_q.period;
  assign high_count   = res_q.high;
  assign timeout      = res_q.timeout;
  assign valid        = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: PWM patterns, stuck inputs, handshake, enable and reset cases.
// A timestamp-based reference model predicts every output each cycle.
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int N    = 10;
  localparam int SS   = 2;
  localparam int MAXV = (1 << N) - 1;

  logic         clk;
  logic         rst;
  logic         ena;
  logic         pwm_in;
  logic         ready;
  logic [N-1:0] period_count;
  logic [N-1:0] high_count;
  logic         timeout;
  logic         valid;
  logic         overrun;

  pwm_capture #(.N(N), .SYNC_STAGES(SS)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .pwm_in      (pwm_in),
    .period_count(period_count),
    .high_count  (high_count),
    .timeout     (timeout),
    .valid       (valid),
    .ready       (ready),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- stimulus driver ----------------
  int per_r      = 1;
  int hi_r       = 0;
  int ph         = 0;
  bit rnd_ready  = 1'b0;
  bit drove_rise = 1'b0;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      logic nv;
      @(posedge clk);
      #1;
      nv         = (ph < hi_r);
      drove_rise = nv & ~pwm_in;
      pwm_in     = nv;
      ph         = (ph + 1 >= per_r) ? 0 : ph + 1;
      if (rnd_ready) ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic set_pattern(input int p, input int h);
    per_r = p;
    hi_r  = h;
    ph    = 0;
  endtask

  // ---------------- reference model ----------------
  // The synchronized level seen by the measurement is pwm_in from SS+1 cycles
  // earlier. Periods are differences of rise timestamps, high time is the
  // number of high cycles in the stored level history between them.
  int       cyc = 0;
  bit       live = 1'b0;
  logic [4:0] hist = '0;
  bit       lvl_mem [0:4095];
  int       mode = 0;          // 0 off, 1 waiting for rise, 2 measuring
  int       ref_t = 0;
  int       start_t = 0;
  int       e_per = 0, e_high = 0;
  bit       e_to = 1'b0, e_valid = 1'b0, e_ovr = 1'b0;
  int       acc_cnt = 0, acc_per = 0, acc_high = 0;
  bit       acc_to = 1'b0;

  always @(negedge clk) begin
    bit emit;
    int r_per, r_high;
    bit r_to, lv, rs;
    if (live) begin
      check_eq("valid", valid, e_valid);
      check_eq("overrun", overrun, e_ovr);
      check_eq("period", period_count, e_per);
      check_eq("high", high_count, e_high);
      check_eq("timeout", timeout, e_to);
      if (valid === 1'b1 && ready === 1'b1) begin
        acc_cnt++;
        acc_per  = int'(period_count);
        acc_high = int'(high_count);
        acc_to   = timeout;
      end
    end
    if (rst) begin
      live    = 1'b1;
      hist    = '0;
      mode    = 0;
      e_per   = 0;
      e_high  = 0;
      e_to    = 1'b0;
      e_valid = 1'b0;
      e_ovr   = 1'b0;
    end else if (live) begin
      hist = {hist[3:0], pwm_in};
      lv   = hist[3];
      rs   = hist[3] & ~hist[4];
      lvl_mem[cyc % 4096] = lv;
      emit   = 1'b0;
      r_per  = 0;
      r_high = 0;
      r_to   = 1'b0;
      if (!ena) begin
        mode = 0;
      end else if (mode == 0) begin
        mode  = 1;
        ref_t = cyc + 1;
      end else if (mode == 1) begin
        if (rs) begin
          mode    = 2;
          start_t = cyc;
        end else if (cyc - ref_t >= MAXV) begin
          emit   = 1'b1;
          r_per  = MAXV;
          r_high = lv ? MAXV : 0;
          r_to   = 1'b1;
          ref_t  = cyc + 1;
        end
      end else begin
        if (rs) begin
          emit  = 1'b1;
          r_per = cyc - start_t;
          for (int k = start_t; k < cyc; k++) r_high += int'(lvl_mem[k % 4096]);
          start_t = cyc;
        end else if (cyc - start_t >= MAXV) begin
          emit   = 1'b1;
          r_per  = MAXV;
          r_high = lv ? MAXV : 0;
          r_to   = 1'b1;
          mode   = 1;
          ref_t  = cyc + 1;
        end
      end
      if (emit) begin
        if (!e_valid || ready) begin
          e_per   = r_per;
          e_high  = r_high;
          e_to    = r_to;
          e_valid = 1'b1;
        end else begin
          e_ovr = 1'b1;
        end
      end else if (e_valid && ready) begin
        e_valid = 1'b0;
      end
    end
    cyc++;
  end

  // ---------------- scenarios ----------------
  initial begin
    int c0;
    rst    = 1'b1;
    ena    = 1'b0;
    pwm_in = 1'b0;
    ready  = 1'b0;
    tick(3);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_overrun", overrun, 0);
    check_eq("rst_period", period_count, 0);
    check_eq("rst_high", high_count, 0);
    check_eq("rst_timeout", timeout, 0);
    rst = 1'b0;

    // Steady 241/60 PWM with the consumer always ready.
    set_pattern(241, 60);
    ready = 1'b1;
    ena   = 1'b1;
    c0    = acc_cnt;
    tick(241 * 6);
    check_eq("steady_period", acc_per, 241);
    check_eq("steady_high", acc_high, 60);
    check_eq("steady_timeout", acc_to, 0);
    check_eq("steady_count_ok", (acc_cnt - c0 >= 4), 1);

    // Consumer stalls for several periods: first result held, later ones dropped.
    ready = 1'b0;
    tick(241 * 3);
    check_eq("hs_overrun", overrun, 1);
    check_eq("hs_valid_held", valid, 1);
    check_eq("hs_period_held", period_count, 241);
    // Release ready exactly in the cycle a new result is emitted.
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (drove_rise) break;
    end
    tick(SS + 1);
    c0    = acc_cnt;
    ready = 1'b1;
    tick(1);
    check_eq("hs_accepted", acc_cnt - c0, 1);
    check_eq("hs_valid_reload", valid, 1);

    // Enable dropped in the middle of a high phase, re-raised 10 cycles later.
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (drove_rise) break;
    end
    tick(30);
    ena = 1'b0;
    tick(10);
    ena = 1'b1;
    tick(241 * 3);
    check_eq("ena_period", acc_per, 241);
    check_eq("ena_high", acc_high, 60);

    // Reset while measuring the low phase with a result pending.
    ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (drove_rise) break;
    end
    tick(100);
    check_eq("pre_rst_valid", valid, 1);
    rst = 1'b1;
    tick(1);
    check_eq("mid_rst_valid", valid, 0);
    check_eq("mid_rst_overrun", overrun, 0);
    check_eq("mid_rst_period", period_count, 0);
    check_eq("mid_rst_high", high_count, 0);
    check_eq("mid_rst_timeout", timeout, 0);
    rst = 1'b0;

    // Stuck low from arming: periodic timeout records with a low level.
    set_pattern(1, 0);
    ready = 1'b1;
    tick(2100);
    check_eq("stuck0_period", acc_per, MAXV);
    check_eq("stuck0_high", acc_high, 0);
    check_eq("stuck0_timeout", acc_to, 1);

    // Input high through reset: the synthetic rise starts a measurement, then it times out high.
    set_pattern(1, 1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2100);
    check_eq("stuck1_period", acc_per, MAXV);
    check_eq("stuck1_high", acc_high, MAXV);
    check_eq("stuck1_timeout", acc_to, 1);

    // Extremes: shortest pulse, longest measurable period, first period that times out.
    set_pattern(3, 1);
    tick(60);
    check_eq("min_period", acc_per, 3);
    check_eq("min_high", acc_high, 1);
    check_eq("min_timeout", acc_to, 0);
    set_pattern(MAXV, 400);
    tick(MAXV * 4);
    check_eq("max_period", acc_per, MAXV);
    check_eq("max_high", acc_high, 400);
    check_eq("max_timeout", acc_to, 0);
    set_pattern(MAXV + 1, 400);
    tick((MAXV + 1) * 3);
    check_eq("over_period", acc_per, MAXV);
    check_eq("over_high", acc_high, 0);
    check_eq("over_timeout", acc_to, 1);

    // Random short patterns, random ready, occasional enable drops.
    rnd_ready = 1'b1;
    for (int it = 0; it < 40; it++) begin
      int p;
      p = int'($urandom_range(2, 40));
      set_pattern(p, int'($urandom_range(1, p - 1)));
      tick(int'($urandom_range(3 * p, 6 * p)));
      if ($urandom_range(0, 7) == 0) begin
        ena = 1'b0;
        tick(int'($urandom_range(1, 5)));
        ena = 1'b1;
      end
    end
    rnd_ready = 1'b0;
    ready     = 1'b1;
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform and reports, once per period, its period and high time in `clk` cycles. It is the receive-side counterpart of the team's PWM generator. Typical uses are gate-drive feedback and loopback checks, where it reports back the duty the driver actually produced. Results leave through a single-entry valid/ready output register, and dead (stuck) inputs are flagged by a timeout.

## Interface
- `N`, default 16: width of the period and high-time counters; saturation value MAX = 2^N-1.
- `SYNC_STAGES`, default 2: number of synchronizer flops on `pwm_in` (minimum 2).

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `ena`, in, 1: measurement enable.
- `pwm_in`, in, 1: asynchronous PWM input.
- `period_count`, out, N: clk cycles between two consecutive detected rising edges.
- `high_count`, out, N: cycles the synchronized input was high within that period.
- `timeout`, out, 1: the current result is a timeout record, not a measured period.
- `valid`, out, 1: result registers hold an unconsumed result.
- `ready`, in, 1: consumer accepts the result when `valid && ready`.
- `overrun`, out, 1: sticky; a result was dropped because the previous one was still pending.

## Operation
- **Input conditioning:** `pwm_in` passes through `SYNC_STAGES` flops, then one previous-level flop.
  - rise = sync & ~prev; fall = ~sync & prev.
  - All of these flops reset to 0. A high input at reset therefore produces one genuine-looking rising edge, and that edge is treated as real.
- **FSM states:** IDLE, ARMED, MEAS_HIGH, MEAS_LOW.
  - IDLE: counters held at 0. Moves to ARMED when `ena`=1.
  - ARMED: waits for a rise. `cnt_period` increments as an idle watchdog. On a rise: `cnt_period`=1, `cnt_high`=1, go to MEAS_HIGH.
  - MEAS_HIGH: `cnt_period`++ and `cnt_high`++ each cycle. On a fall: `cnt_period`++, go to MEAS_LOW.
  - MEAS_LOW: `cnt_period`++ each cycle. On a rise: emit (`period_count`=`cnt_period`, `high_count`=`cnt_high`, `timeout`=0), then restart with `cnt_period`=1, `cnt_high`=1 and go to MEAS_HIGH.
- **Timeout:** in ARMED, MEAS_HIGH or MEAS_LOW, if `cnt_period`=MAX and no rise occurs this cycle, emit a timeout record and return to ARMED with counters at 0.
  - Record contents: `period_count`=MAX, `timeout`=1.
  - `high_count`=MAX if the synchronized level is high, else 0.
  - In a constant-level input this repeats every MAX+1 cycles.
- **`ena` deasserted** in any state: go to IDLE next cycle and clear counters. Any partial period is discarded; no emit. A pending result is retained.
- **Emit rules:**
  - If `valid`=0, or `valid && ready` in the same cycle: load the result registers and set `valid`=1.
  - Otherwise, drop the new result, keep the old one, and set `overrun`=1.
  - Accept with no new result: `valid`=0.
- **Width rules:** counters saturate at MAX and never wrap. Since `high_count` ≤ `period_count`, duty = `high_count`/`period_count`; no division happens in this block.

## Timing
- **Reset values:** all outputs 0 (`period_count`, `high_count`, `timeout`, `valid`, `overrun`). FSM in IDLE.
- **Edge detection latency:** `pwm_in` edge → internal rise/fall is SYNC_STAGES+1 cycles.
- **Result latency:** the result for a period appears on `valid` one cycle after the closing rise is detected, i.e. SYNC_STAGES+2 cycles after the `pwm_in` rising edge.
- `valid` stays high, and the result stays stable, until accepted. `ready` is allowed to be high while `valid`=0.
- The first result after arming or after a timeout requires two rises (one full period).
- **Pulse limits:** pulses and gaps shorter than 1 cycle after synchronization are not resolved. The minimum measurable high or low time is 1 cycle.
- **`rst` mid-measurement:** everything returns to reset values on the next edge, including `overrun`, which is cleared only by `rst`.

## Structure
- Shared package `pwm_pkg`:
  - FSM state enum typedef `pwm_cap_state_t`.
  - Result struct `pwm_result_t {period, high, timeout}`, parameterized via N in the module.
- Sub-module `sync_edge`: SYNC_STAGES synchronizer plus prev flop; outputs `level`, `rise`, `fall`.
- Top module: FSM, counters, output register and handshake. Target size ~150–250 lines total.

## Test plan
All scenarios run with N=10 (MAX=1023) and SYNC_STAGES=2.
- **Steady PWM:** drive the team PWM generator (241-cycle period, duty 60), `ready`=1 → after the first period, every result has `period_count`=241, `high_count`=60, `timeout`=0.
- **Stuck input:** `pwm_in` held 0 from arming → timeout record (1023, 0, 1) every 1024 cycles. Held 1 after one rise → (1023, 1023, 1).
- **Handshake:** `ready`=0 over two periods → first result held, `overrun`=1. Assert `ready` → first result accepted; a new result arriving in the same cycle loads with `valid` staying 1.
- **`ena` toggle:** drop `ena` mid-high, re-raise it 10 cycles later → no partial result; the next result is a full 241/60 period.
- **Reset:** assert `rst` during MEAS_LOW with `valid`=1 → next cycle all outputs are 0 and the FSM is in IDLE. Input high at reset → measurement starts from the synthetic rise.
- **Extremes:** high=1 with period=3 → (3, 1). Period 1023 exactly → measured, not timed out. Period 1024 → timeout record.
